// File: rtl/axi4s_pkg.sv
// -----------------------------------------------------------------------------
// axi4s_pkg
// Shared types and constants for the AXI4-Stream packet transmitter.
//   pkt_tx_state_e  : transmitter FSM states (HDR is only reachable when the
//                     AXI4S_PKT_TX_HDR_EN build option is defined)
//   AXI4S_HDR_MAGIC : upper 16 bits of the optional packet header word
// -----------------------------------------------------------------------------
package axi4s_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2,
      GAP  = 2'd3
   } pkt_tx_state_e;

   localparam logic [15:0] AXI4S_HDR_MAGIC = 16'hA55A;

endpackage

// File: rtl/axi4s_pkt_tx.sv
// -----------------------------------------------------------------------------
// axi4s_pkt_tx
// AXI4-Stream packet source. A start request in IDLE captures len/base/gap and
// emits len incrementing words (base, base+1, ...) with tlast on the final
// word, honouring tready backpressure, then keeps tvalid low for gap cycles.
//
// Build option: AXI4S_PKT_TX_HDR_EN -- when defined, every packet is preceded
// by one header word {16'hA55A, len} (zero-extended / truncated to DW).
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   start           : packet request, only sampled in IDLE
//   len, base, gap  : word count, first payload value, post-packet idle cycles
//   busy            : high whenever the FSM is not in IDLE
//   done            : one-cycle pulse after the final payload handshake
//   pkt_cnt         : completed packet counter (wraps)
//   tdata, tvalid, tlast, tready : AXI4-Stream source port
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module axi4s_pkt_tx
   import axi4s_pkg::*;
#(
   parameter int DW   = 32,
   parameter int LENW = 16,
   parameter int GAPW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [LENW-1:0] len,
   input  logic [DW-1:0]   base,
   input  logic [GAPW-1:0] gap,
   output logic            busy,
   output logic            done,
   output logic [31:0]     pkt_cnt,
   output logic [DW-1:0]   tdata,
   output logic            tvalid,
   input  logic            tready,
   output logic            tlast
);

   pkt_tx_state_e   state_reg, state_next;
   // Words still to be sent after the one currently presented; tlast is
   // asserted when this reaches zero.
   logic [LENW-1:0] rem_reg, rem_next;
   // Holds the captured gap until the packet ends, then counts down in GAP.
   logic [GAPW-1:0] gcnt_reg, gcnt_next;
   logic [DW-1:0]   tdata_reg, tdata_next;
   logic            tvalid_reg, tvalid_next;
   logic            tlast_reg, tlast_next;
   logic            busy_reg, busy_next;
   logic            done_reg, done_next;
   logic [31:0]     pkt_cnt_reg, pkt_cnt_next;

   logic            hs;
   logic            accept;

   assign hs     = tvalid_reg && tready;
   assign accept = start && (len != '0);

`ifdef AXI4S_PKT_TX_HDR_EN
   localparam int HW = 16 + LENW;

   // Base is only needed after the header has gone out.
   logic [DW-1:0] base_reg, base_next;
   logic [HW-1:0] hdr_raw;
   logic [DW-1:0] hdr_word;

   assign hdr_raw = {AXI4S_HDR_MAGIC, len};

   generate
      if (DW > HW) begin : g_hdr_pad
         assign hdr_word = {{(DW-HW){1'b0}}, hdr_raw};
      end else begin : g_hdr_trunc
         assign hdr_word = hdr_raw[DW-1:0];
      end
   endgenerate
`endif

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         rem_reg     <= '0;
         gcnt_reg    <= '0;
         tdata_reg   <= '0;
         tvalid_reg  <= 1'b0;
         tlast_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         pkt_cnt_reg <= '0;
`ifdef AXI4S_PKT_TX_HDR_EN
         base_reg    <= '0;
`endif
      end else begin
         state_reg   <= state_next;
         rem_reg     <= rem_next;
         gcnt_reg    <= gcnt_next;
         tdata_reg   <= tdata_next;
         tvalid_reg  <= tvalid_next;
         tlast_reg   <= tlast_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         pkt_cnt_reg <= pkt_cnt_next;
`ifdef AXI4S_PKT_TX_HDR_EN
         base_reg    <= base_next;
`endif
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
`ifdef AXI4S_PKT_TX_HDR_EN
               state_next = HDR;
`else
               state_next = DATA;
`endif
            end
         end
`ifdef AXI4S_PKT_TX_HDR_EN
         HDR: begin
            if (hs) state_next = DATA;
         end
`endif
         DATA: begin
            if (hs && tlast_reg) state_next = (gcnt_reg != '0) ? GAP : IDLE;
         end
         GAP: begin
            if (gcnt_reg == GAPW'(1)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------ registered outputs
   always_comb begin
      rem_next     = rem_reg;
      gcnt_next    = gcnt_reg;
      tdata_next   = tdata_reg;
      tvalid_next  = tvalid_reg;
      tlast_next   = tlast_reg;
      done_next    = 1'b0;
      pkt_cnt_next = pkt_cnt_reg;
      // busy mirrors the state the FSM is about to enter.
      busy_next    = (state_next != IDLE);
`ifdef AXI4S_PKT_TX_HDR_EN
      base_next    = base_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (accept) begin
               rem_next    = len - LENW'(1);
               gcnt_next   = gap;
               tvalid_next = 1'b1;
`ifdef AXI4S_PKT_TX_HDR_EN
               base_next   = base;
               tdata_next  = hdr_word;
               tlast_next  = 1'b0;
`else
               tdata_next  = base;
               tlast_next  = (len == LENW'(1));
`endif
            end
         end
`ifdef AXI4S_PKT_TX_HDR_EN
         HDR: begin
            if (hs) begin
               tdata_next = base_reg;
               tlast_next = (rem_reg == '0);
            end
         end
`endif
         DATA: begin
            if (hs) begin
               if (tlast_reg) begin
                  tvalid_next  = 1'b0;
                  tlast_next   = 1'b0;
                  done_next    = 1'b1;
                  pkt_cnt_next = pkt_cnt_reg + 32'd1;
               end else begin
                  // Incrementing the presented word gives base+i modulo 2^DW.
                  tdata_next = tdata_reg + DW'(1);
                  rem_next   = rem_reg - LENW'(1);
                  tlast_next = (rem_reg == LENW'(1));
               end
            end
         end
         GAP: begin
            gcnt_next = gcnt_reg - GAPW'(1);
         end
         default: ;
      endcase
   end

   assign tdata   = tdata_reg;
   assign tvalid  = tvalid_reg;
   assign tlast   = tlast_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;
   assign pkt_cnt = pkt_cnt_reg;

endmodule

// File: tb/tb_axi4s_pkt_tx.sv
// -----------------------------------------------------------------------------
// tb_axi4s_pkt_tx
// Self-checking bench for axi4s_pkt_tx. A queue of expected stream words is
// filled whenever a request should be accepted; one compare process checks
// every handshake, done, pkt_cnt and stall stability on each falling edge.
// Directed tests add literal expectations. Honours AXI4S_PKT_TX_HDR_EN.
// -----------------------------------------------------------------------------
module tb_axi4s_pkt_tx;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
      logic        h;
   } wexp_t;

   logic        clk, rst, start, tready;
   logic [15:0] len;
   logic [31:0] base;
   logic [7:0]  gap;
   logic        busy, done, tvalid, tlast;
   logic [31:0] pkt_cnt, tdata;

   int          checks = 0;
   int          passes = 0;
   wexp_t       q[$];
   logic [31:0] got[$];
   int          cnt_model = 0;
   int          done_seen = 0;
   bit          done_pend = 0;
   bit          rand_mode = 0;

   axi4s_pkt_tx dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .base(base), .gap(gap),
      .busy(busy), .done(done), .pkt_cnt(pkt_cnt), .tdata(tdata),
      .tvalid(tvalid), .tready(tready), .tlast(tlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ------------------------------------------------------------ compare loop
   initial begin
      wexp_t       e;
      bit          prev_stall = 0;
      logic [31:0] prev_d = '0;
      logic        prev_l = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            cnt_model  = 0;
            done_pend  = 0;
            prev_stall = 0;
         end else begin
            chk("done", {63'd0, done}, {63'd0, done_pend});
            chk("pkt_cnt", {32'd0, pkt_cnt}, 64'(cnt_model));
            if (done) done_seen++;
            if (prev_stall) begin
               chk("stall_tvalid", {63'd0, tvalid}, 64'd1);
               chk("stall_tdata", {32'd0, tdata}, {32'd0, prev_d});
               chk("stall_tlast", {63'd0, tlast}, {63'd0, prev_l});
            end
            done_pend = 0;
            if (tvalid && tready) begin
               if (q.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_word: got %h expected no word", tdata);
               end else begin
                  e = q.pop_front();
                  chk("word_tdata", {32'd0, tdata}, {32'd0, e.d});
                  chk("word_tlast", {63'd0, tlast}, {63'd0, e.l});
                  if (!e.h) got.push_back(tdata);
                  if (e.l) begin
                     done_pend = 1;
                     cnt_model++;
                  end
                  $display("word %h last=%0d hdr=%0d", tdata, tlast, e.h);
               end
            end
            prev_stall = tvalid && !tready;
            prev_d     = tdata;
            prev_l     = tlast;
         end
      end
   end

   // Random backpressure driver.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_mode) tready = 1'($urandom_range(0, 1));
      end
   end

   // Issue a one-cycle start; returns 1 time unit after the sampling edge.
   task automatic send(input logic [15:0] l, input logic [31:0] b,
                       input logic [7:0] g, input bit acc);
      wexp_t e;
      len = l; base = b; gap = g; start = 1'b1;
      if (acc) begin
`ifdef AXI4S_PKT_TX_HDR_EN
         e.d = {16'hA55A, l}; e.l = 1'b0; e.h = 1'b1;
         q.push_back(e);
`endif
         for (int i = 0; i < int'(l); i++) begin
            e.d = b + 32'(i);
            e.l = (i == int'(l) - 1);
            e.h = 1'b0;
            q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (!(busy == 1'b0 && q.size() == 0) && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= bound) begin
         checks++;
         $display("FAIL timeout: got busy after %0d cycles expected idle", n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_seq(input string name, input logic [31:0] b, input int n);
      chk({name, "_count"}, 64'(got.size()), 64'(n));
      for (int i = 0; i < n && i < got.size(); i++)
         chk(name, {32'd0, got[i]}, {32'd0, b + 32'(i)});
   endtask

   // ------------------------------------------------------------- directed
   initial begin
      int gc, n;
      logic [31:0] first_exp;
      void'($urandom(123));
      rst = 1'b1; start = 1'b0; len = '0; base = '0; gap = '0; tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
      chk("rst_tlast", {63'd0, tlast}, 64'd0);
      chk("rst_tdata", {32'd0, tdata}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_pkt_cnt", {32'd0, pkt_cnt}, 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic packet, tready held high.
      got.delete();
`ifdef AXI4S_PKT_TX_HDR_EN
      first_exp = 32'hA55A0004;
`else
      first_exp = 32'h00000010;
`endif
      send(16'd4, 32'h10, 8'd0, 1'b1);
      chk("latency_tvalid", {63'd0, tvalid}, 64'd1);
      chk("latency_tdata", {32'd0, tdata}, {32'd0, first_exp});
      chk("t1_busy", {63'd0, busy}, 64'd1);
      wait_idle(100);
      check_seq("t1_data", 32'h10, 4);
      chk("t1_pkt_cnt", {32'd0, pkt_cnt}, 64'd1);
      chk("t1_done_count", 64'(done_seen), 64'd1);

      // Same packet under random backpressure.
      got.delete();
      rand_mode = 1'b1;
      send(16'd4, 32'h10, 8'd0, 1'b1);
      wait_idle(500);
      rand_mode = 1'b0;
      tready = 1'b1;
      check_seq("t2_data", 32'h10, 4);
      chk("t2_pkt_cnt", {32'd0, pkt_cnt}, 64'd2);

      // Single word with a gap of three cycles.
      got.delete();
      send(16'd1, 32'hFFFFFFFF, 8'd3, 1'b1);
      gc = 0; n = 0;
      while (busy && n < 50) begin
         if (!tvalid) gc++;
         @(posedge clk);
         #1;
         n++;
      end
      chk("t3_gap_cycles", 64'(gc), 64'd3);
      chk("t3_busy_low", {63'd0, busy}, 64'd0);
      check_seq("t3_data", 32'hFFFFFFFF, 1);
      wait_idle(20);

      // Data wrap.
      got.delete();
      send(16'd3, 32'hFFFFFFFE, 8'd0, 1'b1);
      wait_idle(100);
      check_seq("t4_wrap", 32'hFFFFFFFE, 3);
      chk("t4_pkt_cnt", {32'd0, pkt_cnt}, 64'd4);

      // len==0 ignored, mid-packet start ignored.
      got.delete();
      send(16'd0, 32'h77, 8'd0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("t5_len0_busy", {63'd0, busy}, 64'd0);
      chk("t5_len0_cnt", {32'd0, pkt_cnt}, 64'd4);
      send(16'd4, 32'h200, 8'd1, 1'b1);
      @(posedge clk);
      #1;
      send(16'd2, 32'h999, 8'd0, 1'b0);
      wait_idle(100);
      repeat (3) @(posedge clk);
      #1;
      check_seq("t5_data", 32'h200, 4);
      chk("t5_pkt_cnt", {32'd0, pkt_cnt}, 64'd5);

      // Reset mid-packet.
      send(16'd8, 32'h100, 8'd0, 1'b1);
      @(posedge clk);
      #1;
      chk("t6_tvalid_before", {63'd0, tvalid}, 64'd1);
      rst = 1'b1;
      #1;
      chk("t6_rst_tvalid", {63'd0, tvalid}, 64'd0);
      chk("t6_rst_busy", {63'd0, busy}, 64'd0);
      chk("t6_rst_pkt_cnt", {32'd0, pkt_cnt}, 64'd0);
      chk("t6_rst_tdata", {32'd0, tdata}, 64'd0);
      chk("t6_rst_tlast", {63'd0, tlast}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      got.delete();
      send(16'd2, 32'h55, 8'd0, 1'b1);
      wait_idle(100);
      check_seq("t6_recover", 32'h55, 2);
      chk("t6_pkt_cnt", {32'd0, pkt_cnt}, 64'd1);

      repeat (3) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
